// File: rtl/stage3_pkg.sv
// stage3_pkg: shared types and constants for the stage-3 scan scheduler
package stage3_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} sched_state_e;
    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_PINF = 16'h7C00;
    localparam int NMODE = 8;
endpackage

// File: rtl/lane_hit_reduce.sv
// lane_hit_reduce: popcount, highest set lane and any-hit flag of a masked hit vector
module lane_hit_reduce #(
    parameter int PAR = 12
) (
    input  logic [PAR-1:0]             hits,
    output logic [$clog2(PAR+1)-1:0]   cnt,
    output logic [$clog2(PAR)-1:0]     top,
    output logic                       any
);
    localparam int CW = $clog2(PAR + 1);
    localparam int LW = $clog2(PAR);
    always_comb begin
        cnt = '0;
        top = '0;
        for (int i = 0; i < PAR; i++) begin
            cnt = cnt + CW'(hits[i]);
            if (hits[i]) top = LW'(i);
        end
        any = |hits;
    end
endmodule

// File: rtl/stage3_scan_sched.sv
// stage3_scan_sched: bound configuration and lane-group job scheduler for the stage-3 interval check
module stage3_scan_sched #(
    parameter int WIDTH = 16,
    parameter int IDXW  = 16,
    parameter int PAR   = 12,
    parameter int NMODE = stage3_pkg::NMODE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [2:0]             cfg_sel,
    input  logic [WIDTH-1:0]       cfg_lb,
    input  logic [WIDTH-1:0]       cfg_ub,
    output logic [NMODE*WIDTH-1:0] interval_lb,
    output logic [NMODE*WIDTH-1:0] interval_ub,
    input  logic                   start,
    input  logic [IDXW-1:0]        len,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [PAR*IDXW-1:0]    idx_o,
    output logic [PAR-1:0]         lane_en,
    input  logic [PAR-1:0]         hit_i,
    output logic [IDXW-1:0]        hit_cnt,
    output logic [IDXW-1:0]        last_hit_idx
);
    import stage3_pkg::*;
    sched_state_e state;
    logic [IDXW:0] base;
    logic [IDXW-1:0] len_q;
    logic [IDXW:0] next_base;
    logic [IDXW:0] cnt_sum;
    logic [$clog2(PAR+1)-1:0] pc;
    logic [$clog2(PAR)-1:0] top_lane;
    logic any_hit;
    logic run;
    logic beat;
    assign run = state == RUN;
    assign busy = run;
    assign in_ready = run;
    assign done = state == DONE;
    assign beat = run && in_valid;
    // One extra bit keeps lane_en correct when base+i crosses 2^IDXW
    for (genvar i = 0; i < PAR; i++) begin : g_lane
        logic [IDXW:0] lane_sum;
        assign lane_sum = base + (IDXW+1)'(i);
        assign idx_o[i*IDXW +: IDXW] = run ? lane_sum[IDXW-1:0] : '0;
        assign lane_en[i] = run && (lane_sum < {1'b0, len_q});
    end
    lane_hit_reduce #(.PAR(PAR)) u_reduce (
        .hits (hit_i & lane_en),
        .cnt  (pc),
        .top  (top_lane),
        .any  (any_hit)
    );
    assign next_base = base + (IDXW+1)'(PAR);
    assign cnt_sum = {1'b0, hit_cnt} + (IDXW+1)'(pc);
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            base         <= '0;
            len_q        <= '0;
            hit_cnt      <= '0;
            last_hit_idx <= '0;
            interval_lb  <= {NMODE{WIDTH'(FP16_ZERO)}};
            interval_ub  <= {NMODE{WIDTH'(FP16_PINF)}};
        end else begin
            if (state == IDLE && cfg_we) begin
                interval_lb[cfg_sel*WIDTH +: WIDTH] <= cfg_lb;
                interval_ub[cfg_sel*WIDTH +: WIDTH] <= cfg_ub;
            end
            case (state)
                IDLE: if (start) begin
                    len_q        <= len;
                    base         <= '0;
                    hit_cnt      <= '0;
                    last_hit_idx <= '0;
                    state        <= (len == '0) ? DONE : RUN;
                end
                RUN: begin
                    if (beat) begin
                        hit_cnt <= cnt_sum[IDXW] ? '1 : cnt_sum[IDXW-1:0];
                        if (any_hit) last_hit_idx <= base[IDXW-1:0] + IDXW'(top_lane);
                        base <= next_base;
                        if (next_base >= {1'b0, len_q}) state <= DONE;
                    end
                    if (abort) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
